sample_frame_packer: RTL and testbench
======================================

Name: sample_frame_packer

Overview:
- Sits between the two sinc3 decimation filters and the byte-wide UART transmitter.
- On each new-sample strobe, captures the I and U filtered words and emits a fixed 6-byte frame over a valid/ready byte interface: sync, I_hi, I_lo, U_hi, U_lo, checksum.
- Provides one-deep buffering of a sample pair that arrives while a frame is in flight.
- Counts lost sample pairs.

Parameters:
- WIDTH, 16, filtered sample width; legal range 8..16; samples are sign-extended to 16 bits before packing.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- CNT_W, 8, width of the overrun counter.

Ports:
- clk  in  1  system clock (75 MHz domain).
- rst_n  in  1  synchronous, active-low reset.
- sample_stb  in  1  new-sample indication, synchronous to clk; its rising edge marks a new pair, and its level may stay high for many cycles.
- sample_i  in  WIDTH  filtered current sample; stable on the stb rising edge.
- sample_u  in  WIDTH  filtered voltage sample; stable on the stb rising edge.
- tx_data  out  8  frame byte to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts the byte when tx_valid && tx_ready.
- busy  out  1  a frame is in flight (state SEND).
- overrun_cnt  out  CNT_W  number of sample pairs overwritten in the pending buffer; saturating.

Behaviour:
- Reset (rst_n low at a clk edge):
  - tx_valid=0, tx_data=0, busy=0, overrun_cnt=0.
  - Pending buffer empty; state IDLE; byte index 0.
  - stb_q=1, so a strobe that is already high at reset release gives no edge.
- Edge detect: edge = sample_stb & ~stb_q; stb_q <= sample_stb every cycle.
- Frame layout, bytes 0..5:
  - SYNC_BYTE, I[15:8], I[7:0], U[15:8], U[7:0], CHK.
  - CHK = XOR of bytes 1..4.
- Frame register: {I,U} 32 bits, captured when a frame is loaded.
- State IDLE:
  - On edge: load frame registers from the inputs.
  - Next cycle: SEND, index 0, tx_valid=1, tx_data=SYNC_BYTE.
  - Latency from edge cycle to tx_valid is 1 clk.
- State SEND:
  - tx_data = byte[index]; tx_valid=1.
  - tx_data and tx_valid are held unchanged while tx_valid && !tx_ready.
  - On acceptance with index<5: index+1 the next cycle.
- Acceptance at index 5:
  - If pending is full: load frame from pending, clear pending, stay in SEND, index 0. tx_valid stays high with no gap.
  - Else if edge occurs in the same cycle: load frame directly from the inputs and restart at index 0.
  - Else: go to IDLE with tx_valid=0.
- Edge while in SEND and not at final acceptance:
  - If pending is empty: store the pair in pending.
  - If pending is full: overwrite pending (latest pair wins) and increment overrun_cnt, saturating at all-ones.
- Edge at final acceptance with pending full:
  - Pending goes to the frame; the new pair goes to pending.
  - No overrun is counted.
- busy is 1 exactly when the state is SEND.
- rst_n low mid-frame: the frame is abandoned, all outputs return to reset values the next cycle, and pending is discarded.
- No combinational path from tx_ready to tx_valid or tx_data; all outputs are registered.

Decomposition:
- Package sample_frame_pkg holds:
  - FRAME_LEN=6.
  - Byte-index typedef (3 bits).
  - Default SYNC_BYTE.
  - State enum {IDLE, SEND}.
  - A function computing CHK from a 32-bit {I,U}.
- One natural sub-module, strobe_edge_det: stb_q register with reset to 1, output edge pulse.
- The remaining logic (FSM, pending buffer, counter, byte mux) stays in the top module.

Test Plan:
1. Basic frame: WIDTH=16, I=16'h1234, U=16'hABCD, tx_ready tied 1, one strobe edge. Expect tx_valid the next cycle and 6 consecutive bytes A5, 12, 34, AB, CD, 40, then tx_valid=0 and busy=0.
2. Backpressure: same samples, tx_ready low for 3 cycles at index 2. Expect tx_data held at 34 with tx_valid=1 throughout, then the frame completes unchanged.
3. Sign extension: WIDTH=12, I=12'h800, U=12'h7FF. Expect bytes A5, F8, 00, 07, FF, then CHK = F8^00^07^FF = 00.
4. Back-to-back with overrun: tx_ready toggling at 1/8 duty; three edges during one frame with pairs P1, P2, P3. Expect the second frame to carry P3, overrun_cnt=1, and the next frame to start with no idle cycle.
5. Reset behaviour: sample_stb high through rst_n deassertion produces no frame. Asserting rst_n at index 3 gives tx_valid=0, busy=0, overrun_cnt=0 the next cycle; a new edge afterwards yields a full frame starting at A5.
6. Saturation: force 300 overruns with CNT_W=8. Expect overrun_cnt to stick at 8'hFF.

Source files
------------

// File: rtl/sample_frame_packer_pkg.sv
// Shared types and constants for the sample frame packer.
package sample_frame_pkg;

    // Bytes per frame: sync, I_hi, I_lo, U_hi, U_lo, checksum.
    localparam int FRAME_LEN = 6;

    typedef logic [2:0] byte_idx_t;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_LEN - 1);

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Checksum is the XOR of the four payload bytes taken from {I,U}.
    function automatic logic [7:0] frame_chk(input logic [31:0] pair);
        return pair[31:24] ^ pair[23:16] ^ pair[15:8] ^ pair[7:0];
    endfunction

endpackage

// File: rtl/sample_frame_packer_edge_det.sv
// Rising-edge detector for the sample strobe. The history flop resets to 1
// so a strobe that is already high when reset releases is not an edge.
module strobe_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic stb_in,
    output logic stb_edge
);

    logic stb_q;
    logic stb_d;

    // Next history value is simply the current strobe level.
    always_comb begin
        stb_d = stb_in;
    end

    // Strobe history register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stb_q <= 1'b1;
        end else begin
            stb_q <= stb_d;
        end
    end

    assign stb_edge = stb_in & ~stb_q;

endmodule

// File: rtl/sample_frame_packer.sv
// Packs each new I/U sample pair into a 6-byte frame (sync, I_hi, I_lo,
// U_hi, U_lo, checksum) and streams it to a byte-wide UART.
//
// Byte handshake: tx_data/tx_valid are registered; a byte moves on a clock
// edge where tx_valid && tx_ready. Once tx_valid is high it stays high and
// tx_data stays unchanged until that byte is accepted. tx_ready never feeds
// tx_valid or tx_data combinationally.
//
// A pair arriving mid-frame waits in a one-deep pending buffer; a later
// pair overwrites it (newest wins) and bumps a saturating overrun counter.
module sample_frame_packer
    import sample_frame_pkg::*;
#(
    parameter int         WIDTH     = 16,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_stb,
    input  logic [WIDTH-1:0] sample_i,
    input  logic [WIDTH-1:0] sample_u,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [CNT_W-1:0] overrun_cnt
);

    state_t           state_q, state_d;
    byte_idx_t        idx_q, idx_d;
    logic [31:0]      frame_q, frame_d;
    logic [31:0]      pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0] ovr_q, ovr_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;

    logic             stb_edge;
    logic [15:0]      i_ext;
    logic [15:0]      u_ext;
    logic [31:0]      pair_in;
    logic             accept;
    logic             last_accept;
    byte_idx_t        idx_inc;

    strobe_edge_det u_edge_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .stb_in   (sample_stb),
        .stb_edge (stb_edge)
    );

    // Byte mux: selects the frame byte at a given index.
    function automatic logic [7:0] frame_byte(input logic [31:0] pair,
                                              input byte_idx_t   idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = pair[31:24];
            3'd2:    b = pair[23:16];
            3'd3:    b = pair[15:8];
            3'd4:    b = pair[7:0];
            default: b = frame_chk(pair);
        endcase
        return b;
    endfunction

    // Sign-extend the filter words to 16 bits and form the {I,U} pair.
    always_comb begin
        i_ext   = 16'($signed(sample_i));
        u_ext   = 16'($signed(sample_u));
        pair_in = {i_ext, u_ext};
    end

    // FSM next state, pending buffer, overrun counter and output byte.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ovr_d      = ovr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;

        accept      = tx_valid_q && tx_ready;
        last_accept = (state_q == SEND) && accept && (idx_q == LAST_IDX);
        idx_inc     = idx_q + 3'd1;

        unique case (state_q)
            IDLE: begin
                if (stb_edge) begin
                    frame_d    = pair_in;
                    state_d    = SEND;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                end
            end

            SEND: begin
                if (last_accept) begin
                    if (pend_vld_q) begin
                        // Chain straight into the buffered pair; a pair
                        // arriving now refills the buffer without loss.
                        frame_d    = pend_q;
                        idx_d      = '0;
                        tx_valid_d = 1'b1;
                        tx_data_d  = SYNC_BYTE;
                        if (stb_edge) begin
                            pend_d = pair_in;
                        end else begin
                            pend_vld_d = 1'b0;
                        end
                    end else if (stb_edge) begin
                        frame_d    = pair_in;
                        idx_d      = '0;
                        tx_valid_d = 1'b1;
                        tx_data_d  = SYNC_BYTE;
                    end else begin
                        state_d    = IDLE;
                        idx_d      = '0;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                    end
                end else begin
                    if (accept) begin
                        idx_d     = idx_inc;
                        tx_data_d = frame_byte(frame_q, idx_inc);
                    end
                    if (stb_edge) begin
                        pend_d = pair_in;
                        if (pend_vld_q) begin
                            if (ovr_q != {CNT_W{1'b1}}) begin
                                ovr_d = ovr_q + CNT_W'(1);
                            end
                        end else begin
                            pend_vld_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                idx_d      = '0;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

    // State, buffer and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            frame_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ovr_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ovr_q      <= ovr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = (state_q == SEND);
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_sample_frame_packer.sv
// Directed bench for sample_frame_packer: a 16-bit instance carries most
// scenarios, a 12-bit instance covers sign extension.
module tb_sample_frame_packer;

  logic        clk;
  logic        rst_n;

  // 16-bit instance
  logic        stb;
  logic [15:0] s_i;
  logic [15:0] s_u;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [7:0]  ovr_cnt;

  // 12-bit instance
  logic        stb12;
  logic [11:0] s_i12;
  logic [11:0] s_u12;
  logic [7:0]  tx_data12;
  logic        tx_valid12;
  logic        tx_ready12;
  logic        busy12;
  logic [7:0]  ovr_cnt12;

  int          n_cmp;
  int          n_err;
  logic [7:0]  exp_q[$];

  sample_frame_packer #(.WIDTH(16), .SYNC_BYTE(8'hA5), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_stb  (stb),
    .sample_i    (s_i),
    .sample_u    (s_u),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .overrun_cnt (ovr_cnt)
  );

  sample_frame_packer #(.WIDTH(12), .SYNC_BYTE(8'hA5), .CNT_W(8)) dut12 (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_stb  (stb12),
    .sample_i    (s_i12),
    .sample_u    (s_u12),
    .tx_data     (tx_data12),
    .tx_valid    (tx_valid12),
    .tx_ready    (tx_ready12),
    .busy        (busy12),
    .overrun_cnt (ovr_cnt12)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4,
                            input logic [7:0] chk);
    exp_q.push_back(8'hA5);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    exp_q.push_back(b4);
    exp_q.push_back(chk);
  endtask

  task automatic wait_idle(input int max_cyc);
    logic done;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      tick();
      if (!tx_valid && exp_q.size() == 0) done = 1'b1;
    end
    check_eq("idle_reached", 32'(done), 32'd1);
  endtask

  // ---------------- scoreboard monitor (16-bit instance) ----------------
  // Inputs change 1 ns after posedge, so at negedge valid/ready are the
  // values the next posedge will see.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_byte_queue_size", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check_eq("tx_byte", 32'(tx_data), 32'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    stb        = 1'b0;
    s_i        = '0;
    s_u        = '0;
    tx_ready   = 1'b0;
    stb12      = 1'b0;
    s_i12      = '0;
    s_u12      = '0;
    tx_ready12 = 1'b0;

    tick(); tick(); tick();
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data",  32'(tx_data),  32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);
    check_eq("rst_overrun",  32'(ovr_cnt),  32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // 1. basic frame, ready always high
    tx_ready = 1'b1;
    s_i = 16'h1234;
    s_u = 16'hABCD;
    push_frame(8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40);
    stb = 1'b1;
    tick();
    check_eq("t1_valid_latency", 32'(tx_valid), 32'd1);
    check_eq("t1_first_byte",    32'(tx_data),  32'hA5);
    check_eq("t1_busy",          32'(busy),     32'd1);
    stb = 1'b0;
    wait_idle(20);
    check_eq("t1_end_valid", 32'(tx_valid), 32'd0);
    check_eq("t1_end_busy",  32'(busy),     32'd0);
    tick();

    // 2. backpressure at index 2
    push_frame(8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40);
    stb = 1'b1;
    tick();
    stb = 1'b0;
    tick();
    tick();
    tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("t2_hold_data",  32'(tx_data),  32'h34);
      check_eq("t2_hold_valid", 32'(tx_valid), 32'd1);
    end
    tx_ready = 1'b1;
    wait_idle(20);
    tick();

    // 3. sign extension on the 12-bit instance
    tx_ready12 = 1'b1;
    s_i12 = 12'h800;
    s_u12 = 12'h7FF;
    stb12 = 1'b1;
    tick();
    stb12 = 1'b0;
    check_eq("t3_b0", 32'(tx_data12), 32'hA5);
    tick();
    check_eq("t3_b1", 32'(tx_data12), 32'hF8);
    tick();
    check_eq("t3_b2", 32'(tx_data12), 32'h00);
    tick();
    check_eq("t3_b3", 32'(tx_data12), 32'h07);
    tick();
    check_eq("t3_b4", 32'(tx_data12), 32'hFF);
    tick();
    check_eq("t3_chk", 32'(tx_data12), 32'h00);
    check_eq("t3_chk_valid", 32'(tx_valid12), 32'd1);
    tick();
    check_eq("t3_end_valid", 32'(tx_valid12), 32'd0);

    // 4. back-to-back with one overrun; ready at 1/8 duty
    tx_ready = 1'b0;
    s_i = 16'h0102;
    s_u = 16'h0304;
    push_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    push_frame(8'hA1, 8'hB2, 8'hC3, 8'hE4, 8'h34);
    stb = 1'b1;
    tick();
    gap = 0;
    for (int k = 1; k < 200; k++) begin
      tx_ready = (k % 8 == 0);
      stb      = (k == 5 || k == 15);
      if (k == 5) begin
        s_i = 16'h1020;
        s_u = 16'h3040;
      end
      if (k == 15) begin
        s_i = 16'hA1B2;
        s_u = 16'hC3E4;
      end
      tick();
      if (exp_q.size() > 0 && !tx_valid) gap++;
      if (k > 20 && exp_q.size() == 0 && !tx_valid) break;
    end
    stb = 1'b0;
    tx_ready = 1'b1;
    check_eq("t4_queue_drained", 32'(exp_q.size()), 32'd0);
    check_eq("t4_no_gap",        32'(gap),          32'd0);
    check_eq("t4_overrun",       32'(ovr_cnt),      32'd1);
    check_eq("t4_end_busy",      32'(busy),         32'd0);

    // 5a. strobe high through reset release gives no frame
    stb = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check_eq("t5_no_frame_valid", 32'(tx_valid), 32'd0);
    check_eq("t5_no_frame_busy",  32'(busy),     32'd0);
    stb = 1'b0;
    tick(); tick();

    // 5b. reset at index 3 with a pair pending
    tx_ready = 1'b1;
    s_i = 16'hBEEF;
    s_u = 16'h0001;
    push_frame(8'hBE, 8'hEF, 8'h00, 8'h01, 8'h50);
    stb = 1'b1;
    tick();
    stb = 1'b0;
    tick();
    stb = 1'b1;
    tick();
    stb = 1'b0;
    tick();
    check_eq("t5_at_idx3", 32'(tx_data), 32'h00);
    tx_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    check_eq("t5_rst_valid",   32'(tx_valid), 32'd0);
    check_eq("t5_rst_busy",    32'(busy),     32'd0);
    check_eq("t5_rst_data",    32'(tx_data),  32'd0);
    check_eq("t5_rst_overrun", 32'(ovr_cnt),  32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    tick();
    tx_ready = 1'b1;
    push_frame(8'hBE, 8'hEF, 8'h00, 8'h01, 8'h50);
    stb = 1'b1;
    tick();
    check_eq("t5_restart_byte", 32'(tx_data), 32'hA5);
    stb = 1'b0;
    wait_idle(20);
    check_eq("t5_end_overrun", 32'(ovr_cnt), 32'd0);
    tick();

    // 6. counter saturation
    tx_ready = 1'b0;
    s_i = 16'h0F1E;
    s_u = 16'hF00D;
    push_frame(8'h0F, 8'h1E, 8'hF0, 8'h0D, 8'hEC);
    stb = 1'b1;
    tick();
    stb = 1'b0;
    tick();
    for (int n = 0; n < 302; n++) begin
      stb = 1'b1;
      tick();
      stb = 1'b0;
      tick();
      if (n == 254) check_eq("t6_overrun_254", 32'(ovr_cnt), 32'hFE);
    end
    check_eq("t6_overrun_sat", 32'(ovr_cnt), 32'hFF);
    push_frame(8'h0F, 8'h1E, 8'hF0, 8'h0D, 8'hEC);
    tx_ready = 1'b1;
    wait_idle(40);
    check_eq("t6_overrun_hold", 32'(ovr_cnt), 32'hFF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
